// File: rtl/fifo_ctrl_pkg.sv
// Shared types for the FIFO access controller: sequencer state encoding,
// requester identifiers and the round-robin successor helper.
package fifo_ctrl_pkg;

    // Sequencer states.
    //   ST_IDLE : arbitrate between producers A/B and the read consumer
    //   ST_WR   : single-cycle FIFO write strobe
    //   ST_RCHK : burst check (done / FIFO empty / issue another read)
    //   ST_RD   : single-cycle FIFO read strobe
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RCHK = 2'd2,
        ST_RD   = 2'd3
    } state_t;

    // Requester identifiers; also the bit positions in the arbiter request vector.
    typedef enum logic [1:0] {
        REQ_A = 2'd0,
        REQ_B = 2'd1,
        REQ_R = 2'd2
    } req_id_t;

    localparam int NUM_REQ = 3;

    // Round-robin successor: A -> B -> R -> A.
    function automatic req_id_t next_id(input req_id_t id);
        req_id_t nxt;
        case (id)
            REQ_A:   nxt = REQ_B;
            REQ_B:   nxt = REQ_R;
            default: nxt = REQ_A;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/rr_arb3.sv
// Three-way round-robin arbiter with a drain-priority override for the
// read requester. The grant is combinational from the request vector and
// the registered pointer; the pointer only moves when the caller consumes
// a grant (advance high while a grant is valid).
module rr_arb3
    import fifo_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req,        // indexed by req_id_t
    input  logic       prio_r,     // R wins outright when it is requesting
    input  logic       advance,    // grant is taken this cycle
    output logic       gnt_valid,
    output logic [1:0] gnt_id
);

    req_id_t ptr;
    req_id_t cand0;
    req_id_t cand1;
    req_id_t cand2;
    req_id_t winner;

    // Search order starts at the pointer and walks the ring once.
    assign cand0 = ptr;
    assign cand1 = next_id(cand0);
    assign cand2 = next_id(cand1);

    // Pick the winner: override first, then the first requester in ring order.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        gnt_valid = 1'b0;
        winner    = REQ_A;
        if (prio_r && req[REQ_R]) begin
            gnt_valid = 1'b1;
            winner    = REQ_R;
        end else if (req[cand0]) begin
            gnt_valid = 1'b1;
            winner    = cand0;
        end else if (req[cand1]) begin
            gnt_valid = 1'b1;
            winner    = cand1;
        end else if (req[cand2]) begin
            gnt_valid = 1'b1;
            winner    = cand2;
        end
    end

    assign gnt_id = winner;

    // Move the pointer to the requester after the winner once a grant is consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= REQ_A;
        end else if (advance && gnt_valid) begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            ptr <= next_id(winner);
        end
    end

endmodule

// File: rtl/fifo_access_ctrl.sv
// Sequencer in front of the FIFO datapath. Shares the single write port
// between producers A and B and runs bounded read bursts for consumer R,
// using the FIFO status flags so no write hits a full FIFO and no read hits
// an empty one. Every strobe is followed by a non-strobe cycle, which gives
// the combinational status flags time to reflect the previous pointer move
// before the next decision. All outputs are registered.
module fifo_access_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int BURST_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,

    // Producer A
    input  logic               wr_req_a,
    input  logic [DATA_W-1:0]  wr_data_a,
    output logic               wr_ack_a,

    // Producer B
    input  logic               wr_req_b,
    input  logic [DATA_W-1:0]  wr_data_b,
    output logic               wr_ack_b,

    // Read consumer
    input  logic               rd_req,
    input  logic [BURST_W-1:0] rd_len,
    output logic               rd_busy,
    output logic               rd_done,
    output logic [BURST_W-1:0] rd_count,
    output logic               rd_short,

    // FIFO status
    input  logic               fifo_full,
    input  logic               fifo_empty,
    input  logic               fifo_threshold,

    // FIFO strobes and write data
    output logic               fifo_we,
    output logic               fifo_rd,
    output logic [DATA_W-1:0]  fifo_din
);

    state_t             state;
    logic [BURST_W-1:0] remaining;

    logic [2:0]         arb_req;
    logic               arb_advance;
    logic               gnt_valid;
    logic [1:0]         gnt_id;

    // Eligibility: producers only when there is room; the reader is held off
    // for the rd_done cycle so a level-held rd_req cannot restart immediately.
    assign arb_req[REQ_A] = wr_req_a & ~fifo_full;
    assign arb_req[REQ_B] = wr_req_b & ~fifo_full;
    assign arb_req[REQ_R] = rd_req & ~rd_done;

    // Grants are only consumed while the sequencer sits in IDLE.
    assign arb_advance = (state == ST_IDLE);

    rr_arb3 u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (arb_req),
        .prio_r    (fifo_threshold),
        .advance   (arb_advance),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    // Sequencer: state, burst counters and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            remaining <= '0;
            fifo_we   <= 1'b0;
            fifo_rd   <= 1'b0;
            fifo_din  <= '0;
            wr_ack_a  <= 1'b0;
            wr_ack_b  <= 1'b0;
            rd_busy   <= 1'b0;
            rd_done   <= 1'b0;
            rd_count  <= '0;
            rd_short  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // rd_done marks only the first IDLE cycle after a burst.
                    rd_done <= 1'b0;
                    if (gnt_valid) begin
                        case (gnt_id)
                            REQ_A: begin
                                fifo_din <= wr_data_a;
                                fifo_we  <= 1'b1;
                                wr_ack_a <= 1'b1;
                                state    <= ST_WR;
                            end
                            REQ_B: begin
                                fifo_din <= wr_data_b;
                                fifo_we  <= 1'b1;
                                wr_ack_b <= 1'b1;
                                state    <= ST_WR;
                            end
                            default: begin
                                // Burst length is captured here; later rd_len changes are ignored.
                                rd_busy   <= 1'b1;
                                remaining <= rd_len;
                                rd_count  <= '0;
                                rd_short  <= 1'b0;
                                state     <= ST_RCHK;
                            end
                        endcase
                    end
                end

                ST_WR: begin
                    // Write strobe and ack last exactly one cycle.
                    fifo_we  <= 1'b0;
                    wr_ack_a <= 1'b0;
                    wr_ack_b <= 1'b0;
                    state    <= ST_IDLE;
                end

                ST_RCHK: begin
                    if (remaining == '0) begin
                        // Requested length satisfied.
                        rd_busy  <= 1'b0;
                        rd_done  <= 1'b1;
                        rd_short <= 1'b0;
                        state    <= ST_IDLE;
                    end else if (fifo_empty) begin
                        // FIFO ran dry before the requested length.
                        rd_busy  <= 1'b0;
                        rd_done  <= 1'b1;
                        rd_short <= 1'b1;
                        state    <= ST_IDLE;
                    end else begin
                        fifo_rd <= 1'b1;
                        state   <= ST_RD;
                    end
                end

                ST_RD: begin
                    // One word consumed; return to the check so the flags can settle.
                    fifo_rd   <= 1'b0;
                    remaining <= remaining - BURST_W'(1);
                    rd_count  <= rd_count + BURST_W'(1);
                    state     <= ST_RCHK;
                end

                default: begin
                    fifo_we  <= 1'b0;
                    fifo_rd  <= 1'b0;
                    wr_ack_a <= 1'b0;
                    wr_ack_b <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_access_ctrl.sv
// Self-checking bench for fifo_access_ctrl. A small FIFO occupancy model
// drives the status flags; expected writes and burst results are queued
// when stimulus is applied and compared when the DUT produces them.
module tb_fifo_access_ctrl;

    localparam int DATA_W  = 8;
    localparam int BURST_W = 4;
    localparam int DEPTH   = 8;
    localparam int THR     = 6;

    logic               clk;
    logic               rst_n;
    logic               wr_req_a;
    logic [DATA_W-1:0]  wr_data_a;
    logic               wr_ack_a;
    logic               wr_req_b;
    logic [DATA_W-1:0]  wr_data_b;
    logic               wr_ack_b;
    logic               rd_req;
    logic [BURST_W-1:0] rd_len;
    logic               rd_busy;
    logic               rd_done;
    logic [BURST_W-1:0] rd_count;
    logic               rd_short;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_threshold;
    logic               fifo_we;
    logic               fifo_rd;
    logic [DATA_W-1:0]  fifo_din;

    fifo_access_ctrl #(.DATA_W(DATA_W), .BURST_W(BURST_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wr_req_a       (wr_req_a),
        .wr_data_a      (wr_data_a),
        .wr_ack_a       (wr_ack_a),
        .wr_req_b       (wr_req_b),
        .wr_data_b      (wr_data_b),
        .wr_ack_b       (wr_ack_b),
        .rd_req         (rd_req),
        .rd_len         (rd_len),
        .rd_busy        (rd_busy),
        .rd_done        (rd_done),
        .rd_count       (rd_count),
        .rd_short       (rd_short),
        .fifo_full      (fifo_full),
        .fifo_empty     (fifo_empty),
        .fifo_threshold (fifo_threshold),
        .fifo_we        (fifo_we),
        .fifo_rd        (fifo_rd),
        .fifo_din       (fifo_din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- counters and scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic              src;   // 0 = A, 1 = B
        logic [DATA_W-1:0] data;
    } wr_exp_t;

    typedef struct packed {
        logic [BURST_W-1:0] count;
        logic               short_f;
    } rd_exp_t;

    wr_exp_t exp_wr[$];
    rd_exp_t exp_rd[$];
    int      we_cyc[$];
    int      rd_cyc[$];
    logic [31:0] ev_hist;
    wr_exp_t mon_we;
    rd_exp_t mon_rd;
    int      rd_pulses;
    int      busy_cnt;
    int      cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- FIFO occupancy model ----------------
    int   fifo_base;
    int   n_we;
    int   n_rd;
    int   level;
    logic force_full;

    assign level          = fifo_base + n_we - n_rd;
    assign fifo_full      = force_full || (level >= DEPTH);
    assign fifo_empty     = (level <= 0);
    assign fifo_threshold = (level >= THR);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_we) n_we <= n_we + 1;
        if (fifo_rd) n_rd <= n_rd + 1;
    end

    task automatic set_level(input int l);
        fifo_base = l - (n_we - n_rd);
    endtask

    // ---------------- output monitor ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            rd_pulses = 0;
            busy_cnt  = 0;
        end else begin
            if (fifo_we) begin
                check("we_into_full", fifo_full, 0);
                check("we_rd_overlap", fifo_rd, 0);
                we_cyc.push_back(cyc);
                ev_hist = {ev_hist[23:0], "W"};
                check("we_expected", 32'(exp_wr.size() != 0), 1);
                if (exp_wr.size() != 0) begin
                    mon_we = exp_wr.pop_front();
                    check("we_din", fifo_din, mon_we.data);
                    check("we_ack_a", wr_ack_a, !mon_we.src);
                    check("we_ack_b", wr_ack_b, mon_we.src);
                end
            end else if (wr_ack_a || wr_ack_b) begin
                check("ack_without_we", fifo_we, 1);
            end
            if (fifo_rd) begin
                check("rd_from_empty", fifo_empty, 0);
                rd_cyc.push_back(cyc);
                ev_hist = {ev_hist[23:0], "R"};
                rd_pulses++;
            end
            if (rd_busy) busy_cnt++;
            if (rd_done) begin
                check("done_expected", 32'(exp_rd.size() != 0), 1);
                if (exp_rd.size() != 0) begin
                    mon_rd = exp_rd.pop_front();
                    check("rd_count", rd_count, mon_rd.count);
                    check("rd_short", rd_short, mon_rd.short_f);
                    check("rd_pulses", rd_pulses, mon_rd.count);
                    check("busy_cycles", busy_cnt, 2 * mon_rd.count + 1);
                end
                check("busy_at_done", rd_busy, 0);
                rd_pulses = 0;
                busy_cnt  = 0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Advance one cycle; producers/consumer drop their request once served.
    task automatic step();
        @(negedge clk);
        #1;
        if (wr_ack_a) wr_req_a = 1'b0;
        if (wr_ack_b) wr_req_b = 1'b0;
        if (rd_done)  rd_req   = 1'b0;
    endtask

    task automatic wait_quiet(input string tag);
        int   n;
        logic done;
        n    = 0;
        done = 1'b0;
        while (!done && n < 200) begin
            step();
            n++;
            if (exp_wr.size() == 0 && exp_rd.size() == 0 && !rd_busy && !fifo_we &&
                !fifo_rd && !wr_req_a && !wr_req_b && !rd_req)
                done = 1'b1;
        end
        check({tag, "_timeout"}, done, 1);
        if (done) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    int rel_cyc;
    int drop_cyc;
    int base;
    logic saw;

    initial begin
        cyc        = 0;
        n_we       = 0;
        n_rd       = 0;
        fifo_base  = 2;
        force_full = 1'b0;
        ev_hist    = '0;
        rd_pulses  = 0;
        busy_cnt   = 0;
        rst_n      = 1'b0;
        wr_req_a   = 1'b1;
        wr_data_a  = 8'hA1;
        wr_req_b   = 1'b1;
        wr_data_b  = 8'hB2;
        rd_req     = 1'b1;
        rd_len     = 4'd1;

        // Reset with every request active: outputs must stay zero.
        repeat (3) step();
        check("reset_outputs",
              32'({fifo_we, fifo_rd, fifo_din, wr_ack_a, wr_ack_b, rd_busy, rd_done, rd_count, rd_short}),
              0);

        // Release: round-robin A, B, R from the reset pointer.
        exp_wr.push_back('{src: 1'b0, data: 8'hA1});
        exp_wr.push_back('{src: 1'b1, data: 8'hB2});
        exp_rd.push_back('{count: 4'd1, short_f: 1'b0});
        base    = we_cyc.size();
        rel_cyc = cyc;
        rst_n   = 1'b1;
        wait_quiet("rr");
        check("rr_order", ev_hist, "WWR");
        check("rr_first_we_cycle", we_cyc[base], rel_cyc + 1);
        check("rr_we_spacing", we_cyc[base + 1] - we_cyc[base], 2);

        // Full stall: no write while full, write right after full drops.
        set_level(0);
        force_full = 1'b1;
        wr_data_a  = 8'h5C;
        wr_req_a   = 1'b1;
        exp_wr.push_back('{src: 1'b0, data: 8'h5C});
        ev_hist = '0;
        repeat (20) step();
        check("stall_no_we", ev_hist, 0);
        check("stall_req_held", wr_req_a, 1);
        drop_cyc   = cyc;
        force_full = 1'b0;
        wait_quiet("stall");
        check("stall_release_cycle", we_cyc[we_cyc.size() - 1], drop_cyc + 1);

        // Short burst: 3 words available, 5 requested.
        set_level(3);
        rd_len  = 4'd5;
        rd_req  = 1'b1;
        exp_rd.push_back('{count: 4'd3, short_f: 1'b1});
        base    = rd_cyc.size();
        ev_hist = '0;
        wait_quiet("short");
        check("short_events", ev_hist, "RRR");
        check("short_gap0", rd_cyc[base + 1] - rd_cyc[base], 2);
        check("short_gap1", rd_cyc[base + 2] - rd_cyc[base + 1], 2);
        check("short_held", {rd_count, rd_short}, {4'd3, 1'b1});

        // Zero-length burst: completes without reads, not short.
        set_level(3);
        rd_len  = 4'd0;
        rd_req  = 1'b1;
        exp_rd.push_back('{count: 4'd0, short_f: 1'b0});
        ev_hist = '0;
        wait_quiet("len0");
        check("len0_no_rd", ev_hist, 0);

        // Empty FIFO at grant: nothing read, flagged short.
        set_level(0);
        rd_len  = 4'd3;
        rd_req  = 1'b1;
        exp_rd.push_back('{count: 4'd0, short_f: 1'b1});
        ev_hist = '0;
        wait_quiet("empty");
        check("empty_no_rd", ev_hist, 0);

        // Threshold override with pointer at A: R first, then A, B.
        set_level(6);
        wr_data_a = 8'h11;
        wr_data_b = 8'h22;
        rd_len    = 4'd1;
        wr_req_a  = 1'b1;
        wr_req_b  = 1'b1;
        rd_req    = 1'b1;
        exp_rd.push_back('{count: 4'd1, short_f: 1'b0});
        exp_wr.push_back('{src: 1'b0, data: 8'h11});
        exp_wr.push_back('{src: 1'b1, data: 8'h22});
        ev_hist = '0;
        wait_quiet("thr");
        check("thr_order", ev_hist, "RWW");

        // Mid-burst reset: abort during a read strobe.
        set_level(4);
        rd_len = 4'd4;
        rd_req = 1'b1;
        saw    = 1'b0;
        for (int i = 0; i < 20 && !saw; i++) begin
            step();
            if (fifo_rd) saw = 1'b1;
        end
        check("midrst_saw_rd", saw, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_rd_drop", fifo_rd, 0);
        check("midrst_busy_drop", rd_busy, 0);
        rd_req = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
        check("midrst_after", 32'({rd_busy, rd_done, rd_count, rd_short}), 0);
        repeat (5) step();

        // Pointer back at A after reset: A served before B.
        wr_data_a = 8'h3A;
        wr_data_b = 8'h3B;
        wr_req_a  = 1'b1;
        wr_req_b  = 1'b1;
        exp_wr.push_back('{src: 1'b0, data: 8'h3A});
        exp_wr.push_back('{src: 1'b1, data: 8'h3B});
        ev_hist = '0;
        wait_quiet("post_rst");
        check("post_rst_events", ev_hist, "WW");

        check("wr_queue_drained", exp_wr.size(), 0);
        check("rd_queue_drained", exp_rd.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
